if_id_skid_stage: RTL and testbench

//  IF->ID pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/if_id_skid_stage_if.sv | 26 ++
 rtl/if_id_skid_stage.sv | 60 ++++++
 tb/tb_if_id_skid_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/if_id_skid_stage_if.sv
// rtl/if_id_skid_stage_if.sv - IF->ID handshake bundle (fetch side, decode side, flush)
interface if_id_skid_stage_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [1:0]         occupancy;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, occupancy
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, occupancy
  );
endinterface

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF->ID stage register with 2-entry skid buffer and flush
module if_id_skid_stage #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  if_id_skid_stage_if.slave  bus
);
  logic               m_valid;
  logic [INSTR_W-1:0] m_instr;
  logic [PC_W-1:0]    m_pc;
  logic               s_valid;
  logic [INSTR_W-1:0] s_instr;
  logic [PC_W-1:0]    s_pc;
  logic               in_fire;
  logic               out_fire;

  // in_ready depends only on registered state, so decode stalls never ripple back combinationally
  assign bus.in_ready  = !s_valid;
  assign in_fire       = bus.in_valid && !s_valid;
  assign out_fire      = m_valid && bus.out_ready;
  assign bus.out_valid = m_valid;
  assign bus.out_instr = m_instr & {INSTR_W{m_valid}};
  assign bus.out_pc    = m_pc & {PC_W{m_valid}};
  assign bus.occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_instr <= '0;
      m_pc    <= '0;
      s_valid <= 1'b0;
      s_instr <= '0;
      s_pc    <= '0;
    end else if (bus.flush) begin
      // data fields are left stale; the output mask hides them
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      if (out_fire) begin
        m_instr <= s_instr;
        m_pc    <= s_pc;
        s_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!m_valid || out_fire) begin
        m_instr <= bus.in_instr;
        m_pc    <= bus.in_pc;
        m_valid <= 1'b1;
      end else begin
        s_instr <= bus.in_instr;
        s_pc    <= bus.in_pc;
        s_valid <= 1'b1;
      end
    end else if (out_fire) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - scoreboard bench for if_id_skid_stage
module tb_if_id_skid_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  logic [63:0] q[$];

  if_id_skid_stage_if #(.INSTR_W(32), .PC_W(32)) bus ();

  if_id_skid_stage #(.INSTR_W(32), .PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] head;
    head = (q.size() > 0) ? q[0] : 64'h0;
    chk({tag, ".out_valid"}, {31'h0, bus.out_valid}, {31'h0, q.size() > 0});
    chk({tag, ".out_instr"}, bus.out_instr, head[63:32]);
    chk({tag, ".out_pc"},    bus.out_pc,    head[31:0]);
    chk({tag, ".in_ready"},  {31'h0, bus.in_ready}, {31'h0, q.size() < 2});
    chk({tag, ".occupancy"}, {30'h0, bus.occupancy}, q.size());
  endtask

  // Entered just after a rising edge; drives one cycle, checks, then advances the model.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy, input logic fl);
    logic inf, outf;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    check_model(tag);
    inf  = iv && (q.size() < 2);
    outf = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({ins, pc});
    end
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #2;
    check_model("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // streaming at full rate
    cycle("stream0", 1'b1, 32'h00000013, 32'h00, 1'b1, 1'b0);
    cycle("stream1", 1'b1, 32'h00100093, 32'h04, 1'b1, 1'b0);
    cycle("stream2", 1'b1, 32'h00200113, 32'h08, 1'b1, 1'b0);
    cycle("stream3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("stream_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // stall fills the skid entry, then release
    cycle("stall0", 1'b1, 32'h8C820000, 32'h10, 1'b0, 1'b0);
    cycle("stall1", 1'b1, 32'h00000020, 32'h14, 1'b0, 1'b0);
    cycle("stall_full", 1'b1, 32'h00000020, 32'h14, 1'b0, 1'b0);
    cycle("stall_rel", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("stall_next", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("stall_drained", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // flush with both entries held and fetch presenting 0x18
    cycle("fl_fill0", 1'b1, 32'h11111111, 32'h20, 1'b0, 1'b0);
    cycle("fl_fill1", 1'b1, 32'h22222222, 32'h24, 1'b0, 1'b0);
    cycle("fl_flush", 1'b1, 32'h33333333, 32'h18, 1'b0, 1'b1);
    cycle("fl_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush discards a same-cycle in_fire and counts a same-cycle out_fire
    cycle("fl2_fill", 1'b1, 32'h44444444, 32'h28, 1'b0, 1'b0);
    cycle("fl2_flush", 1'b1, 32'h55555555, 32'h2C, 1'b1, 1'b1);
    cycle("fl2_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // simultaneous in/out fire at occupancy 1
    cycle("sim_fill", 1'b1, 32'h66666666, 32'h30, 1'b0, 1'b0);
    cycle("sim_both", 1'b1, 32'h77777777, 32'h34, 1'b1, 1'b0);
    cycle("sim_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset with occupancy 2
    cycle("rst_fill0", 1'b1, 32'hAAAA0001, 32'h40, 1'b0, 1'b0);
    cycle("rst_fill1", 1'b1, 32'hAAAA0002, 32'h44, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    #1;
    check_model("rst_pre");
    #1;
    reset = 1'b0;
    #1;
    q.delete();
    check_model("rst_async");
    @(posedge clk);
    #1;
    check_model("rst_held");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.push_back({32'hAAAA0002, 32'h44});
    check_model("rst_first_capture");

    // random valid/ready/flush against the reference queue
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(i * 4);
      cycle("rand", 1'($urandom_range(0, 1)), $urandom, pc,
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end
    cycle("rand_drain0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("rand_drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("rand_drain2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
